// File: rtl/bus_bridge_mc.sv
// -----------------------------------------------------------------------------
// bus_bridge_mc
//
// Multi-cycle bridge from the CPU bus port to NUM_SLAVES memory-mapped slaves
// (DRAM, seven-segment display, LEDs, switches, buttons). Each access is decoded
// against programmable base/mask windows. A hit selects one slave and waits for
// that slave's ready. A miss, or a slave that stays silent for TIMEOUT cycles,
// completes with cpu_err=1 and ERR_DATA.
//
// Ports
//   cpu_clk, cpu_rst_n  clock (rising edge), asynchronous active-low reset
//   cpu_req             request, sampled only while idle (not queued while busy)
//   cpu_addr/wen/wdata  access address, direction (1=write), write data
//   cpu_rdata           read data; valid with cpu_ready, held until next completion
//   cpu_ready           one-cycle completion pulse
//   cpu_err             error qualifier, valid with cpu_ready, held afterwards
//   busy                high while an access is in flight (ACCESS or RESP)
//   slv_sel             one-hot slave select, active only during ACCESS
//   slv_addr/slv_wdata  latched address / write data
//   slv_wen             latched write enable, gated by ACCESS
//   slv_rdata           flattened per-slave read data, slave i at [32i+31:32i]
//   slv_ready           per-slave ready; only the selected bit is observed
// -----------------------------------------------------------------------------
module bus_bridge_mc #(
    parameter int                       NUM_SLAVES = 5,
    parameter logic [32*NUM_SLAVES-1:0] SLV_BASE   = {32'hFFFF_F078, 32'hFFFF_F070,
                                                      32'hFFFF_F060, 32'hFFFF_F000,
                                                      32'h0000_0000},
    parameter logic [32*NUM_SLAVES-1:0] SLV_MASK   = {32'hFFFF_FFFC, 32'hFFFF_FFFC,
                                                      32'hFFFF_FFFC, 32'hFFFF_FFE0,
                                                      32'hFFFF_0000},
    parameter int                       TIMEOUT    = 16,
    parameter logic [31:0]              ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst_n,
    input  logic                       cpu_req,
    input  logic [31:0]                cpu_addr,
    input  logic                       cpu_wen,
    input  logic [31:0]                cpu_wdata,
    output logic [31:0]                cpu_rdata,
    output logic                       cpu_ready,
    output logic                       cpu_err,
    output logic                       busy,
    output logic [NUM_SLAVES-1:0]      slv_sel,
    output logic [31:0]                slv_addr,
    output logic                       slv_wen,
    output logic [31:0]                slv_wdata,
    input  logic [32*NUM_SLAVES-1:0]   slv_rdata,
    input  logic [NUM_SLAVES-1:0]      slv_ready
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       addr_q,  addr_d;
    logic              wen_q,   wen_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              err_q,   err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              hit_any;
    logic [IDX_W-1:0]  hit_idx;
    logic              sel_ready;
    logic [31:0]       sel_rdata;

    // -------------------------------------------------------------------------
    // Address decode: first matching window in ascending index order wins, so
    // overlapping windows resolve to the lowest index.
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in a combinational block gets a default at the
    // top of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!hit_any &&
                ((cpu_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Only the latched slave's ready and read data reach the datapath; other
    // slaves' lines (including X on their read data) are never looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ready = slv_ready[i];
                sel_rdata = slv_rdata[32*i +: 32];
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    state_d = hit_any ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: begin
                // Ready is checked first, so ready on the last allowed cycle wins
                // over the timeout.
                if (sel_ready || (cnt_q == CNT_LAST)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        cpu_ready = (state_q == ST_RESP);
        busy      = (state_q != ST_IDLE);
        slv_wen   = (state_q == ST_ACCESS) && wen_q;
        slv_sel   = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            slv_sel[i] = (state_q == ST_ACCESS) && (idx_q == IDX_W'(i));
        end
    end

    assign slv_addr  = addr_q;
    assign slv_wdata = wdata_q;
    assign cpu_rdata = rdata_q;
    assign cpu_err   = err_q;

    // -------------------------------------------------------------------------
    // Datapath next-state: request latch, wait counter, response registers.
    // rdata/err only change on a completion, so they hold between accesses.
    // -------------------------------------------------------------------------
    always_comb begin
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    wen_d   = cpu_wen;
                    wdata_d = cpu_wdata;
                    idx_d   = hit_idx;
                    cnt_d   = '0;
                    if (!hit_any) begin
                        err_d   = 1'b1;
                        rdata_d = ERR_DATA;
                    end
                end
            end
            ST_ACCESS: begin
                if (sel_ready) begin
                    err_d = 1'b0;
                    if (!wen_q) begin
                        rdata_d = sel_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // NOTE: these are plain registers, not a memory array, so all of them are
    // reset; the outputs they drive must read zero while reset is asserted.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_bus_bridge_mc.sv
// -----------------------------------------------------------------------------
// tb_bus_bridge_mc
//
// Self-checking bench for bus_bridge_mc. Expected results come from a reference
// model built from the address map as byte ranges and from latency rules
// (miss: 1 cycle, hit: waits+2, timeout: TIMEOUT+1). Outputs are sampled on the
// falling clock edge; inputs are driven on the falling edge as well.
// -----------------------------------------------------------------------------
module tb_bus_bridge_mc;

    localparam int          NS       = 5;
    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic              cpu_clk;
    logic              cpu_rst_n;
    logic              cpu_req;
    logic [31:0]       cpu_addr;
    logic              cpu_wen;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              cpu_err;
    logic              busy;
    logic [NS-1:0]     slv_sel;
    logic [31:0]       slv_addr;
    logic              slv_wen;
    logic [31:0]       slv_wdata;
    logic [32*NS-1:0]  slv_rdata;
    logic [NS-1:0]     slv_ready;

    int checks   = 0;
    int failures = 0;

    // Model state: the response registers hold between completions.
    logic [31:0] last_rdata = '0;
    logic        last_err   = 1'b0;

    bus_bridge_mc #(
        .NUM_SLAVES (NS),
        .TIMEOUT    (TIMEOUT),
        .ERR_DATA   (ERR_DATA)
    ) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_wen   (cpu_wen),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .busy      (busy),
        .slv_sel   (slv_sel),
        .slv_addr  (slv_addr),
        .slv_wen   (slv_wen),
        .slv_wdata (slv_wdata),
        .slv_rdata (slv_rdata),
        .slv_ready (slv_ready)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Address map as inclusive byte ranges; -1 means unmapped.
    function automatic int model_decode(input logic [31:0] a);
        if (a <= 32'h0000_FFFF)                          return 0;
        if (a >= 32'hFFFF_F000 && a <= 32'hFFFF_F01F)    return 1;
        if (a >= 32'hFFFF_F060 && a <= 32'hFFFF_F063)    return 2;
        if (a >= 32'hFFFF_F070 && a <= 32'hFFFF_F073)    return 3;
        if (a >= 32'hFFFF_F078 && a <= 32'hFFFF_F07B)    return 4;
        return -1;
    endfunction

    // Random ready noise on every slave, with the target slave's bit forced.
    task automatic drive_ready(input int idx, input logic rdy);
        slv_ready = NS'($urandom);
        if (idx >= 0) slv_ready[idx] = rdy;
    endtask

    // One complete access: drives it, then checks select, latency and response.
    task automatic run_txn(input string name, input logic [31:0] addr, input logic wen,
                           input logic [31:0] wdata, input int waits, input logic [31:0] rd);
        int            idx;
        int            lat;
        int            acc;
        logic          exp_err;
        logic [31:0]   exp_rdata;
        logic [NS-1:0] exp_sel;
        logic [NS-1:0] one;
        bit            done;
        one = 1;
        idx = model_decode(addr);
        if (idx < 0) begin
            lat = 1; acc = 0; exp_err = 1'b1; exp_rdata = ERR_DATA;
        end else if (waits < TIMEOUT) begin
            lat = waits + 2; acc = waits + 1; exp_err = 1'b0;
            exp_rdata = wen ? last_rdata : rd;
        end else begin
            lat = TIMEOUT + 1; acc = TIMEOUT; exp_err = 1'b1; exp_rdata = ERR_DATA;
        end

        @(negedge cpu_clk);
        checks++;
        if (busy !== 1'b0 || cpu_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s idle: busy=%b cpu_ready=%b expected 0/0", name, busy, cpu_ready);
        end
        cpu_req   = 1'b1;
        cpu_addr  = addr;
        cpu_wen   = wen;
        cpu_wdata = wdata;
        slv_rdata = 'x;
        if (idx >= 0) slv_rdata[32*idx +: 32] = rd;
        drive_ready(idx, 1'b0);

        done = 0;
        for (int k = 1; k <= TIMEOUT + 4 && !done; k++) begin
            @(negedge cpu_clk);
            cpu_req   = 1'b0;
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
            cpu_wen   = 1'($urandom);
            if (cpu_ready === 1'b1) begin
                done = 1;
                checks++;
                if (k != lat) begin
                    failures++;
                    $display("FAIL %s latency: got %0d cycles expected %0d", name, k, lat);
                end
                checks++;
                if (cpu_err !== exp_err) begin
                    failures++;
                    $display("FAIL %s err: got %b expected %b", name, cpu_err, exp_err);
                end
                checks++;
                if (cpu_rdata !== exp_rdata) begin
                    failures++;
                    $display("FAIL %s rdata: got %h expected %h", name, cpu_rdata, exp_rdata);
                end
            end else begin
                exp_sel = (idx >= 0 && k <= acc) ? (one << idx) : '0;
                checks++;
                if (slv_sel !== exp_sel || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s sel cyc%0d: sel=%b busy=%b expected sel=%b busy=1",
                             name, k, slv_sel, busy, exp_sel);
                end
                if (idx >= 0 && k <= acc) begin
                    checks++;
                    if (slv_wen !== wen || slv_addr !== addr || slv_wdata !== wdata) begin
                        failures++;
                        $display("FAIL %s slv bus cyc%0d: wen=%b addr=%h wdata=%h expected %b %h %h",
                                 name, k, slv_wen, slv_addr, slv_wdata, wen, addr, wdata);
                    end
                end
            end
            drive_ready(idx, (idx >= 0 && k == waits + 1));
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s no cpu_ready within %0d cycles (expected at %0d)", name, TIMEOUT + 4, lat);
        end
        last_rdata = exp_rdata;
        last_err   = exp_err;

        @(negedge cpu_clk);
        checks++;
        if (cpu_ready !== 1'b0 || busy !== 1'b0 || cpu_rdata !== exp_rdata || cpu_err !== exp_err) begin
            failures++;
            $display("FAIL %s hold: ready=%b busy=%b rdata=%h err=%b expected 0 0 %h %b",
                     name, cpu_ready, busy, cpu_rdata, cpu_err, exp_rdata, exp_err);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (cpu_ready !== 1'b0 || busy !== 1'b0 || cpu_err !== 1'b0 || cpu_rdata !== 32'h0 ||
            slv_sel !== '0 || slv_wen !== 1'b0 || slv_addr !== 32'h0 || slv_wdata !== 32'h0) begin
            failures++;
            $display("FAIL %s: ready=%b busy=%b err=%b rdata=%h sel=%b wen=%b addr=%h wdata=%h expected all 0",
                     name, cpu_ready, busy, cpu_err, cpu_rdata, slv_sel, slv_wen, slv_addr, slv_wdata);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge cpu_clk);
        check_all_zero("reset");
        cpu_rst_n = 1'b1;
    endtask

    task automatic test_read_zero_wait();
        run_txn("read_s0_zero_wait", 32'h0000_0010, 1'b0, 32'h0, 0, 32'h1234_5678);
    endtask

    task automatic test_write_wait();
        run_txn("write_s2_3wait", 32'hFFFF_F060, 1'b1, 32'hA5A5_0001, 3, 32'h5555_AAAA);
    endtask

    task automatic test_miss();
        run_txn("read_unmapped", 32'h8000_0000, 1'b0, 32'h0, 0, 32'h0);
        run_txn("read_s1_after_miss", 32'hFFFF_F01C, 1'b0, 32'h0, 1, 32'h0BAD_F00D);
    endtask

    task automatic test_timeout();
        run_txn("read_s3_timeout", 32'hFFFF_F070, 1'b0, 32'h0, 1000, 32'h1111_2222);
        run_txn("read_s3_last_cycle", 32'hFFFF_F070, 1'b0, 32'h0, TIMEOUT - 1, 32'h3333_4444);
        run_txn("write_s4_timeout", 32'hFFFF_F07B, 1'b1, 32'h7777_0000, TIMEOUT, 32'h0);
    endtask

    task automatic test_reset_mid();
        @(negedge cpu_clk);
        cpu_req   = 1'b1;
        cpu_addr  = 32'hFFFF_F060;
        cpu_wen   = 1'b1;
        cpu_wdata = 32'hCAFE_0002;
        slv_rdata = 'x;
        slv_ready = '0;
        @(negedge cpu_clk);
        cpu_req = 1'b0;
        checks++;
        if (slv_sel !== 5'b00100) begin
            failures++;
            $display("FAIL reset_mid pre: sel=%b expected 00100", slv_sel);
        end
        @(negedge cpu_clk);
        cpu_rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid immediate");
        for (int k = 0; k < 3; k++) begin
            @(negedge cpu_clk);
            checks++;
            if (cpu_ready !== 1'b0 || slv_sel !== '0) begin
                failures++;
                $display("FAIL reset_mid held: ready=%b sel=%b expected 0", cpu_ready, slv_sel);
            end
        end
        cpu_rst_n  = 1'b1;
        last_rdata = '0;
        last_err   = 1'b0;
        run_txn("read_after_reset", 32'h0000_0044, 1'b0, 32'h0, 2, 32'hC0FF_EE01);
    endtask

    task automatic test_back_to_back();
        int          t1;
        int          t2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        e1;
        logic        e2;
        t1 = -1; t2 = -1; d1 = '0; d2 = '0; e1 = 1'b1; e2 = 1'b1;
        @(negedge cpu_clk);
        cpu_req   = 1'b1;
        cpu_addr  = 32'h0000_0100;
        cpu_wen   = 1'b0;
        slv_rdata = 'x;
        slv_rdata[31:0]    = 32'h0102_0304;
        slv_rdata[159:128] = 32'hF4F3_F2F1;
        slv_ready = 5'b10001;
        for (int k = 1; k <= 12 && t2 < 0; k++) begin
            @(negedge cpu_clk);
            cpu_addr = 32'hFFFF_F078;
            if (k == 1 || k == 4) begin
                checks++;
                if (slv_sel !== ((k == 1) ? 5'b00001 : 5'b10000)) begin
                    failures++;
                    $display("FAIL b2b sel cyc%0d: sel=%b", k, slv_sel);
                end
            end
            if (cpu_ready === 1'b1) begin
                if (t1 < 0) begin
                    t1 = k; d1 = cpu_rdata; e1 = cpu_err;
                end else begin
                    t2 = k; d2 = cpu_rdata; e2 = cpu_err;
                    cpu_req = 1'b0;
                end
            end
        end
        cpu_req   = 1'b0;
        slv_ready = '0;
        checks++;
        if (t1 != 2 || t2 - t1 != 3) begin
            failures++;
            $display("FAIL b2b timing: first ready cyc %0d (exp 2), second cyc %0d (exp 5)", t1, t2);
        end
        checks++;
        if (d1 !== 32'h0102_0304 || e1 !== 1'b0) begin
            failures++;
            $display("FAIL b2b first: rdata=%h err=%b expected 01020304 0", d1, e1);
        end
        checks++;
        if (d2 !== 32'hF4F3_F2F1 || e2 !== 1'b0) begin
            failures++;
            $display("FAIL b2b second: rdata=%h err=%b expected f4f3f2f1 0", d2, e2);
        end
        last_rdata = 32'hF4F3_F2F1;
        last_err   = 1'b0;
        @(negedge cpu_clk);
    endtask

    task automatic test_random();
        logic [31:0] lo  [5] = '{32'h0000_0000, 32'hFFFF_F000, 32'hFFFF_F060,
                                 32'hFFFF_F070, 32'hFFFF_F078};
        int          sz  [5] = '{65536, 32, 4, 4, 4};
        logic [31:0] addr;
        int          w;
        int          r;
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 5));
            if (r < 5) addr = lo[r] + $urandom_range(0, sz[r] - 1);
            else       addr = $urandom;
            case ($urandom_range(0, 4))
                0:       w = 0;
                1:       w = TIMEOUT - 1;
                2:       w = TIMEOUT + int'($urandom_range(0, 3));
                default: w = int'($urandom_range(0, 5));
            endcase
            run_txn($sformatf("rand%0d", n), addr, 1'($urandom), $urandom, w, $urandom);
        end
    endtask

    initial begin
        cpu_rst_n = 1'b0;
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        cpu_wen   = 1'b0;
        cpu_wdata = '0;
        slv_rdata = '0;
        slv_ready = '0;

        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_miss();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
